// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port-per-direction RAM with registered read data.
// Round-robin between ports, with an optional lock that keeps one port as sole owner.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic                  wen0,
  input  logic                  wen1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t                  state_reg, state_next;
  logic                    last_gnt_reg;
  logic [ADDR_WIDTH-1:0]   w_addr_reg, r_addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic                    gnt0_next, gnt1_next;
  logic [1:0]              gnt_vec, wen_vec, rvalid_vec;
  logic                    rd_grant;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // A lock only blocks the other port while its owner keeps requesting;
  // once the owner drops req the cycle is arbitrated as if idle.
  always_comb begin
    gnt0_next  = 1'b0;
    gnt1_next  = 1'b0;
    state_next = IDLE;
    if (!reset_n) begin
      gnt0_next = 1'b0;
      gnt1_next = 1'b0;
    end else if (state_reg == LOCK0 && req0) begin
      gnt0_next = 1'b1;
    end else if (state_reg == LOCK1 && req1) begin
      gnt1_next = 1'b1;
    end else if (req0 && req1) begin
      gnt0_next = last_gnt_reg;
      gnt1_next = ~last_gnt_reg;
    end else begin
      gnt0_next = req0;
      gnt1_next = req1;
    end

    if (gnt0_next && lock0) begin
      state_next = LOCK0;
    end else if (gnt1_next && lock1) begin
      state_next = LOCK1;
    end
  end

  assign gnt0    = gnt0_next;
  assign gnt1    = gnt1_next;
  assign gnt_vec = {gnt1_next, gnt0_next};
  assign wen_vec = {wen1, wen0};

  assign sel_addr  = gnt1_next ? addr1  : addr0;
  assign sel_wdata = gnt1_next ? wdata1 : wdata0;
  assign ram_wen   = |(gnt_vec & wen_vec);
  assign rd_grant  = |(gnt_vec & ~wen_vec);

  // Idle cycles replay the last granted values so the RAM pins stay quiet.
  assign ram_w_addr = ram_wen  ? sel_addr  : w_addr_reg;
  assign ram_wdata  = ram_wen  ? sel_wdata : wdata_reg;
  assign ram_r_addr = rd_grant ? sel_addr  : r_addr_reg;
  assign rdata      = ram_rdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      last_gnt_reg <= 1'b1;
      w_addr_reg   <= '0;
      r_addr_reg   <= '0;
      wdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (gnt0_next || gnt1_next) begin
        last_gnt_reg <= gnt1_next;
      end
      if (ram_wen) begin
        w_addr_reg <= sel_addr;
        wdata_reg  <= sel_wdata;
      end
      if (rd_grant) begin
        r_addr_reg <= sel_addr;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rvalid
      logic rvalid_reg;
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= gnt_vec[gi] & ~wen_vec[gi];
        end
      end
      // Gated by reset so a read landing in a reset cycle is never reported.
      assign rvalid_vec[gi] = rvalid_reg & reset_n;
    end
  endgenerate

  assign rvalid0 = rvalid_vec[0];
  assign rvalid1 = rvalid_vec[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios, then a randomized run
// against a small reference arbiter, with a decoupled read-data monitor.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, wen0 = 0, wen1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_wen;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_w_addr, ram_r_addr;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .wen0(wen0), .wen1(wen1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_wen(ram_wen), .ram_w_addr(ram_w_addr),
    .ram_r_addr(ram_r_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM with registered read; contents start as 0x1000_0000 + address
  logic [DW-1:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h1000_0000 + i;
  end
  always @(posedge clk) begin
    if (ram_wen) ram[ram_w_addr] <= ram_wdata;
    ram_rdata <= ram[ram_r_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_rd(bit p, logic [DW-1:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    e.due  = cyc + 1;
    sb_q.push_back(e);
    $display("issue read port%0d expect %08h at cycle %0d", p, d, cyc + 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_gnt(string name, bit e0, bit e1);
    @(negedge clk);
    chk(name, {gnt1, gnt0}, {e1, e0});
  endtask

  // Monitor: independent of stimulus, pops one expectation per rvalid
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      chk("rvalid_missing", 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end
    if (rvalid0 && rvalid1) begin
      chk("rvalid_both", {rvalid1, rvalid0}, 2'b00);
    end else if (rvalid0 || rvalid1) begin
      if (sb_q.size() == 0) begin
        chk("rvalid_spurious", {rvalid1, rvalid0}, 2'b00);
      end else begin
        e = sb_q.pop_front();
        chk("rd_cycle", cyc, e.due);
        chk("rd_port", rvalid1, e.port);
        chk("rd_data", rdata, e.data);
        $display("read port%0d data %08h cycle %0d", rvalid1, rdata, cyc);
      end
    end
  end

  // Reference model state for the random phase
  int            m_state;  // 0 idle, 1 lock0, 2 lock1
  bit            m_last;
  logic [DW-1:0] mem_m [16];
  bit            p0, p1, e0, e1;
  int            w0, w1;

  initial begin
    // Reset behaviour with both ports demanding writes
    tick();
    req0 = 1; req1 = 1; wen0 = 1; wen1 = 1; addr0 = 8'h33; addr1 = 8'h44;
    @(negedge clk);
    chk("rst_gnt", {gnt1, gnt0}, 2'b00);
    chk("rst_wen", ram_wen, 1'b0);
    chk("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
    chk("rst_held", {ram_r_addr, ram_w_addr, ram_wdata}, 48'd0);

    // Post-reset tie: port 0 first, then port 1
    tick();
    reset_n = 1; wen0 = 0; wen1 = 0; addr0 = 8'h10; addr1 = 8'h20;
    expect_gnt("tie_t", 1, 0);
    chk("tie_t_raddr", ram_r_addr, 8'h10);
    push_rd(0, 32'h1000_0010);
    tick();
    req0 = 0;
    expect_gnt("tie_t1", 0, 1);
    chk("tie_t1_raddr", ram_r_addr, 8'h20);
    push_rd(1, 32'h1000_0020);
    tick();
    req1 = 0;
    expect_gnt("idle", 0, 0);
    chk("idle_wen", ram_wen, 1'b0);
    chk("hold_raddr", ram_r_addr, 8'h20);

    // Write then read the same address on the other port
    tick();
    req0 = 1; wen0 = 1; addr0 = 8'h05; wdata0 = 32'hDEAD_BEEF;
    expect_gnt("wr_gnt", 1, 0);
    chk("wr_bus", {ram_wen, ram_w_addr, ram_wdata}, {1'b1, 8'h05, 32'hDEAD_BEEF});
    tick();
    req0 = 0; wen0 = 0; req1 = 1; addr1 = 8'h05;
    expect_gnt("rd_after_wr", 0, 1);
    push_rd(1, 32'hDEAD_BEEF);
    tick();
    req1 = 0;
    @(negedge clk);
    chk("hold_wbus", {ram_wen, ram_w_addr, ram_wdata}, {1'b0, 8'h05, 32'hDEAD_BEEF});

    // Lock on port 1 for three grants while port 0 waits
    tick();
    req0 = 1; addr0 = 8'h11;
    expect_gnt("prime", 1, 0);
    push_rd(0, 32'h1000_0011);
    tick();
    addr0 = 8'h12; req1 = 1; lock1 = 1; addr1 = 8'h21;
    for (int k = 0; k < 3; k++) begin
      expect_gnt($sformatf("lock1_%0d", k), 0, 1);
      push_rd(1, 32'h1000_0021);
      tick();
      if (k == 1) lock1 = 0;
    end
    expect_gnt("lock1_rel", 1, 0);
    push_rd(0, 32'h1000_0012);
    tick();
    req0 = 0;
    expect_gnt("after_rel", 0, 1);
    push_rd(1, 32'h1000_0021);

    // Lock on port 0 released by dropping req0
    tick();
    req1 = 0; req0 = 1; lock0 = 1; addr0 = 8'h13;
    expect_gnt("lock0", 1, 0);
    push_rd(0, 32'h1000_0013);
    tick();
    req0 = 0; lock0 = 0; req1 = 1; addr1 = 8'h22;
    expect_gnt("drop_rel", 0, 1);
    push_rd(1, 32'h1000_0022);

    // Reset while in LOCK1 with a read in flight
    tick();
    lock1 = 1; addr1 = 8'h23;
    expect_gnt("lock1_rd", 0, 1);
    tick();
    reset_n = 0;
    expect_gnt("rst_lock_gnt", 0, 0);
    chk("rst_lock_rvalid", {rvalid1, rvalid0}, 2'b00);
    tick();
    reset_n = 1; lock1 = 0; req0 = 1; addr0 = 8'h14;
    expect_gnt("post_rst_tie", 1, 0);
    chk("post_rst_rvalid", {rvalid1, rvalid0}, 2'b00);
    push_rd(0, 32'h1000_0014);
    tick();
    req0 = 0;
    expect_gnt("post_rst_p1", 0, 1);
    push_rd(1, 32'h1000_0023);
    tick();
    req1 = 0;

    // Random phase against the reference model, addresses 0x80..0x8F
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    m_state = 0; m_last = 1; p0 = 0; p1 = 0; w0 = 0; w1 = 0;
    for (int i = 0; i < 16; i++) mem_m[i] = 32'h1000_0080 + i;
    for (int i = 0; i < 10000; i++) begin
      if (!p0) begin
        req0 = ($urandom_range(0, 2) != 0); lock0 = ($urandom_range(0, 3) == 0);
        wen0 = 1'($urandom_range(0, 1)); addr0 = 8'h80 | 8'($urandom_range(0, 15));
        wdata0 = $urandom;
      end
      if (!p1) begin
        req1 = ($urandom_range(0, 2) != 0); lock1 = ($urandom_range(0, 3) == 0);
        wen1 = 1'($urandom_range(0, 1)); addr1 = 8'h80 | 8'($urandom_range(0, 15));
        wdata1 = $urandom;
      end
      @(negedge clk);
      e0 = 0; e1 = 0;
      if (m_state == 1 && req0) e0 = 1;
      else if (m_state == 2 && req1) e1 = 1;
      else if (req0 && req1) begin e0 = m_last; e1 = !m_last; end
      else begin e0 = req0; e1 = req1; end
      chk("rnd_gnt", {gnt1, gnt0}, {e1, e0});
      if (e0 || e1) begin
        if (e1 ? wen1 : wen0) begin
          chk("rnd_wr", {ram_wen, ram_w_addr, ram_wdata},
              {1'b1, (e1 ? addr1 : addr0), (e1 ? wdata1 : wdata0)});
          mem_m[(e1 ? addr1[3:0] : addr0[3:0])] = e1 ? wdata1 : wdata0;
        end else begin
          chk("rnd_raddr", ram_r_addr, e1 ? addr1 : addr0);
          push_rd(e1, mem_m[(e1 ? addr1[3:0] : addr0[3:0])]);
        end
      end
      if (m_state == 0) begin
        if (e1 && req0) w0++;
        if (e0 && req1) w1++;
      end
      if (e0) begin chk("fair0", (w0 > 1), 1'b0); w0 = 0; end
      if (e1) begin chk("fair1", (w1 > 1), 1'b0); w1 = 0; end
      if (!req0) w0 = 0;
      if (!req1) w1 = 0;
      if (e0) begin m_last = 0; m_state = lock0 ? 1 : 0; end
      else if (e1) begin m_last = 1; m_state = lock1 ? 2 : 0; end
      else m_state = 0;
      p0 = req0 && !e0;
      p1 = req1 && !e1;
      tick();
    end
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    repeat (4) tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
